wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 120 ++++++++++++
 tb/tb_wb_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU and LSU results into a small FIFO that drains
// into a single register-file write port, with starvation protection for the ALU.
module wb_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  alu_valid_i,
    output logic                  alu_ready_o,
    input  logic [5:0]            alu_addr_i,
    input  logic [DATA_WIDTH-1:0] alu_data_i,
    input  logic                  lsu_valid_i,
    output logic                  lsu_ready_o,
    input  logic [5:0]            lsu_addr_i,
    input  logic [DATA_WIDTH-1:0] lsu_data_i,
    input  logic                  wb_stall_i,
    output logic                  we_o,
    output logic [5:0]            w_addr_o,
    output logic [DATA_WIDTH-1:0] w_data_o,
    input  logic [5:0]            rs_addr_i,
    output logic                  rs_pending_o,
    output logic                  busy_o
);

    localparam int PW = $clog2(DEPTH);

    logic [5:0]            addrMem [DEPTH];
    logic [DATA_WIDTH-1:0] dataMem [DEPTH];

    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [PW:0]   count_q, count_d;
    logic [1:0]    starv_q, starv_d;

    logic                  full;
    logic                  aluGrant;
    logic                  lsuGrant;
    logic                  aluFire;
    logic                  lsuFire;
    logic                  push;
    logic                  pop;
    logic [5:0]            inAddr;
    logic [DATA_WIDTH-1:0] inData;
    logic [PW-1:0]         offset;
    logic                  pendingHit;

    // LSU wins by default; a saturated starvation count hands the slot to the ALU.
    always_comb begin
        full        = (count_q == (PW+1)'(DEPTH));
        aluGrant    = alu_valid_i && (!lsu_valid_i || (starv_q == 2'd3));
        lsuGrant    = lsu_valid_i && !aluGrant;
        alu_ready_o = rst_ni && aluGrant && !full;
        lsu_ready_o = rst_ni && lsuGrant && !full;
        aluFire     = alu_valid_i && alu_ready_o;
        lsuFire     = lsu_valid_i && lsu_ready_o;
        inAddr      = aluFire ? alu_addr_i : lsu_addr_i;
        inData      = aluFire ? alu_data_i : lsu_data_i;
        push        = (aluFire || lsuFire) && (inAddr != 6'd0);
        pop         = (count_q != '0) && !wb_stall_i;

        wrPtr_d = push ? wrPtr_q + PW'(1) : wrPtr_q;
        rdPtr_d = pop  ? rdPtr_q + PW'(1) : rdPtr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase

        starv_d = starv_q;
        if (aluFire) begin
            starv_d = 2'd0;
        end else if (alu_valid_i && lsuGrant && (starv_q != 2'd3)) begin
            starv_d = starv_q + 2'd1;
        end
    end

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        pendingHit = 1'b0;
        offset     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PW'(i) - rdPtr_q;
            if (({1'b0, offset} < count_q) && (addrMem[i] == rs_addr_i)) begin
                pendingHit = 1'b1;
            end
        end
        rs_pending_o = pendingHit && (rs_addr_i != 6'd0);
    end

    always_comb begin
        we_o     = (count_q != '0);
        busy_o   = we_o;
        w_addr_o = we_o ? addrMem[rdPtr_q] : 6'd0;
        w_data_o = we_o ? dataMem[rdPtr_q] : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            starv_q <= 2'd0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            starv_q <= starv_d;
        end
    end

    // Storage needs no reset: liveness comes only from the pointers and count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addrMem[wrPtr_q] <= inAddr;
            dataMem[wrPtr_q] <= inData;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter: hand-computed expectations for arbitration,
// buffering, stall, hazard query, x0 discard and reset behaviour.
module tb_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        alu_valid_i;
    logic        alu_ready_o;
    logic [5:0]  alu_addr_i;
    logic [63:0] alu_data_i;
    logic        lsu_valid_i;
    logic        lsu_ready_o;
    logic [5:0]  lsu_addr_i;
    logic [63:0] lsu_data_i;
    logic        wb_stall_i;
    logic        we_o;
    logic [5:0]  w_addr_o;
    logic [63:0] w_data_o;
    logic [5:0]  rs_addr_i;
    logic        rs_pending_o;
    logic        busy_o;

    int compared   = 0;
    int mismatched = 0;

    wb_arbiter #(.DATA_WIDTH(64), .DEPTH(4)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .alu_valid_i (alu_valid_i),
        .alu_ready_o (alu_ready_o),
        .alu_addr_i  (alu_addr_i),
        .alu_data_i  (alu_data_i),
        .lsu_valid_i (lsu_valid_i),
        .lsu_ready_o (lsu_ready_o),
        .lsu_addr_i  (lsu_addr_i),
        .lsu_data_i  (lsu_data_i),
        .wb_stall_i  (wb_stall_i),
        .we_o        (we_o),
        .w_addr_o    (w_addr_o),
        .w_data_o    (w_data_o),
        .rs_addr_i   (rs_addr_i),
        .rs_pending_o(rs_pending_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle 1ns past the edge before new stimulus.
    task automatic applyStimulus;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni = 1'b0;
        alu_valid_i = 1'b1; alu_addr_i = 6'd5; alu_data_i = 64'h1;
        lsu_valid_i = 1'b0; lsu_addr_i = 6'd0; lsu_data_i = 64'h0;
        wb_stall_i = 1'b0; rs_addr_i = 6'd0;
        #12;
        checkOutput("rst_we", we_o, 0);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_waddr", w_addr_o, 0);
        checkOutput("rst_wdata", w_data_o, 0);
        checkOutput("rst_alu_ready", alu_ready_o, 0);
        checkOutput("rst_pending", rs_pending_o, 0);
        alu_valid_i = 1'b0;
        applyStimulus();
        rst_ni = 1'b1;
        applyStimulus();

        // Single ALU write into empty buffer
        alu_valid_i = 1'b1; alu_addr_i = 6'd5; alu_data_i = 64'hA5;
        #1 checkOutput("single_ready", alu_ready_o, 1);
        applyStimulus();
        alu_valid_i = 1'b0;
        checkOutput("single_we", we_o, 1);
        checkOutput("single_waddr", w_addr_o, 5);
        checkOutput("single_wdata", w_data_o, 64'hA5);
        applyStimulus();
        checkOutput("single_we_after", we_o, 0);

        // Both producers valid for 5 cycles: LSU,LSU,LSU,ALU,LSU
        lsu_valid_i = 1'b1; lsu_addr_i = 6'd7; lsu_data_i = 64'h77;
        alu_valid_i = 1'b1; alu_addr_i = 6'd9; alu_data_i = 64'h99;
        for (int c = 0; c < 5; c++) begin
            #1;
            checkOutput($sformatf("arb_lsu_ready_%0d", c), lsu_ready_o, (c == 3) ? 0 : 1);
            checkOutput($sformatf("arb_alu_ready_%0d", c), alu_ready_o, (c == 3) ? 1 : 0);
            applyStimulus();
            checkOutput($sformatf("arb_head_%0d", c), w_addr_o, (c == 3) ? 9 : 7);
        end
        lsu_valid_i = 1'b0; alu_valid_i = 1'b0;
        applyStimulus();
        checkOutput("arb_drained", busy_o, 0);

        // Stalled fill, hazard query, ordered drain
        wb_stall_i = 1'b1;
        for (int a = 1; a <= 4; a++) begin
            alu_valid_i = 1'b1; alu_addr_i = 6'(a); alu_data_i = 64'(16 + a);
            #1 checkOutput($sformatf("fill_ready_%0d", a), alu_ready_o, 1);
            applyStimulus();
        end
        alu_addr_i = 6'd5; alu_data_i = 64'h15;
        #1 checkOutput("full_ready", alu_ready_o, 0);
        alu_valid_i = 1'b0;
        rs_addr_i = 6'd3;
        #1 checkOutput("pending_hit", rs_pending_o, 1);
        rs_addr_i = 6'd6;
        #1 checkOutput("pending_miss", rs_pending_o, 0);
        rs_addr_i = 6'd0;
        #1 checkOutput("pending_x0", rs_pending_o, 0);
        applyStimulus();
        checkOutput("stall_hold", w_addr_o, 1);
        wb_stall_i = 1'b0;
        for (int a = 1; a <= 4; a++) begin
            #1;
            checkOutput($sformatf("drain_we_%0d", a), we_o, 1);
            checkOutput($sformatf("drain_addr_%0d", a), w_addr_o, 6'(a));
            checkOutput($sformatf("drain_data_%0d", a), w_data_o, 64'(16 + a));
            applyStimulus();
        end
        checkOutput("drain_done", we_o, 0);

        // x0 is accepted then dropped; f0 is buffered
        lsu_valid_i = 1'b1; lsu_addr_i = 6'd0; lsu_data_i = 64'hFF;
        #1 checkOutput("x0_ready", lsu_ready_o, 1);
        applyStimulus();
        lsu_addr_i = 6'd32; lsu_data_i = 64'h32;
        checkOutput("x0_busy", busy_o, 0);
        checkOutput("x0_we", we_o, 0);
        applyStimulus();
        lsu_valid_i = 1'b0;
        checkOutput("f0_we", we_o, 1);
        checkOutput("f0_addr", w_addr_o, 32);
        applyStimulus();
        checkOutput("f0_drained", busy_o, 0);

        // Full buffer with a pop: no pass-through, then push+pop holds count at 3
        wb_stall_i = 1'b1;
        for (int a = 11; a <= 14; a++) begin
            alu_valid_i = 1'b1; alu_addr_i = 6'(a); alu_data_i = 64'(a);
            applyStimulus();
        end
        alu_addr_i = 6'd15; alu_data_i = 64'd15; wb_stall_i = 1'b0;
        #1 checkOutput("full_pop_ready", alu_ready_o, 0);
        applyStimulus();
        checkOutput("after_pop_ready", alu_ready_o, 1);
        checkOutput("after_pop_head", w_addr_o, 12);
        applyStimulus();
        checkOutput("pushpop_head", w_addr_o, 13);
        wb_stall_i = 1'b1; alu_addr_i = 6'd16; alu_data_i = 64'd16;
        #1 checkOutput("count3_ready", alu_ready_o, 1);
        applyStimulus();
        alu_addr_i = 6'd17; alu_data_i = 64'd17;
        #1 checkOutput("count4_ready", alu_ready_o, 0);
        alu_valid_i = 1'b0; wb_stall_i = 1'b0;
        for (int a = 13; a <= 16; a++) begin
            #1 checkOutput($sformatf("order_addr_%0d", a), w_addr_o, 6'(a));
            applyStimulus();
        end
        checkOutput("order_done", we_o, 0);

        // Reset mid-operation discards buffered entries
        wb_stall_i = 1'b1;
        lsu_valid_i = 1'b1; lsu_addr_i = 6'd20; lsu_data_i = 64'h20;
        applyStimulus();
        lsu_addr_i = 6'd21; lsu_data_i = 64'h21;
        applyStimulus();
        lsu_valid_i = 1'b0;
        checkOutput("prereset_busy", busy_o, 1);
        rst_ni = 1'b0;
        #1;
        checkOutput("midrst_we", we_o, 0);
        checkOutput("midrst_waddr", w_addr_o, 0);
        applyStimulus();
        rst_ni = 1'b1; wb_stall_i = 1'b0;
        #1 checkOutput("postrst_busy", busy_o, 0);
        for (int c = 0; c < 3; c++) begin
            applyStimulus();
            checkOutput($sformatf("postrst_we_%0d", c), we_o, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
